dcache_store_port: RTL and testbench

//  Data-cache port directly downstream of the store buffer. Accepts one store (drained entry) or
//  one load (store-buffer miss) at a time. Direct-mapped, write-back, write-allocate, 4-word lines.

---
 rtl/dcache_store_port.sv | 161 ++++++++++++++++
 tb/tb_dcache_store_port.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_store_port.sv
// =============================================================================
// Module   : dcache_store_port
// Brief    : Direct-mapped write-back/write-allocate data cache behind the store buffer.
// Revision : 1.0
// =============================================================================
`default_nettype none

module dcache_store_port #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_store,
    input  logic         req_load,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    input  logic         req_type,
    output logic         hit_dc,
    output logic [31:0]  rdata,
    output logic         busy,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wline,
    input  logic         mem_ack,
    input  logic [127:0] mem_rline
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_WB     = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [31:0]         addr_q, wdata_q;
    logic                byte_q, store_q;
    logic [LINES-1:0]    valid_q, dirty_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [127:0]        data_q [LINES];

    logic                hit_dc_d, busy_d, mem_req_d, mem_we_d;
    logic [31:0]         rdata_d, mem_addr_d;
    logic [127:0]        mem_wline_d;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [1:0]            off;
    logic                  lookup_hit;
    logic                  fill_done;

    assign idx        = addr_q[INDEX_BITS+3:4];
    assign req_tag    = addr_q[31:INDEX_BITS+4];
    assign off        = addr_q[3:2];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == req_tag);
    assign fill_done  = (state_q == S_FILL) && mem_ack;

    function automatic logic [127:0] merge_line(input logic [127:0] line, input logic [1:0] woff,
                                                input logic [1:0] lane, input logic is_byte,
                                                input logic [31:0] wd);
        logic [127:0] r;
        r = line;
        if (is_byte) r[{woff, lane, 3'b000} +: 8] = wd[7:0];
        else         r[{woff, 5'b00000} +: 32]    = wd;
        return r;
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hit_dc    <= 1'b0;
            rdata     <= 32'd0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wline <= 128'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            byte_q    <= 1'b0;
            store_q   <= 1'b0;
            valid_q   <= '0;
            dirty_q   <= '0;
        end else begin
            state_q   <= state_d;
            hit_dc    <= hit_dc_d;
            rdata     <= rdata_d;
            busy      <= busy_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wline <= mem_wline_d;
            if (state_q == S_IDLE && (req_store || req_load)) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                byte_q  <= req_type;
                store_q <= req_store;
            end
            if (state_q == S_LOOKUP && lookup_hit && store_q) dirty_q[idx] <= 1'b1;
            if (state_q == S_WB && mem_ack) dirty_q[idx] <= 1'b0;
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= store_q;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits gate them
    always_ff @(posedge clk) begin
        if (state_q == S_LOOKUP && lookup_hit && store_q)
            data_q[idx] <= merge_line(data_q[idx], off, addr_q[1:0], byte_q, wdata_q);
        if (fill_done) begin
            tag_q[idx]  <= req_tag;
            data_q[idx] <= store_q ? merge_line(mem_rline, off, addr_q[1:0], byte_q, wdata_q)
                                   : mem_rline;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_store || req_load) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (lookup_hit)                        state_d = S_DONE;
                else if (valid_q[idx] && dirty_q[idx]) state_d = S_WB;
                else                                   state_d = S_FILL;
            end
            S_WB:     if (mem_ack) state_d = S_FILL;
            S_FILL:   if (mem_ack) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hit_dc_d    = (state_q == S_DONE);
        busy_d      = (state_d != S_IDLE);
        mem_req_d   = (state_d == S_WB) || (state_d == S_FILL);
        mem_we_d    = (state_d == S_WB);
        mem_addr_d  = mem_addr;
        mem_wline_d = mem_wline;
        rdata_d     = rdata;
        if (state_d == S_WB) begin
            mem_addr_d  = {tag_q[idx], idx, 4'b0000};
            mem_wline_d = data_q[idx];
        end else if (state_d == S_FILL) begin
            mem_addr_d  = {req_tag, idx, 4'b0000};
        end
        if (state_q == S_LOOKUP && lookup_hit && !store_q)
            rdata_d = data_q[idx][{off, 5'b00000} +: 32];
        else if (fill_done && !store_q)
            rdata_d = mem_rline[{off, 5'b00000} +: 32];
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache_store_port.sv
// =============================================================================
// Module   : tb_dcache_store_port
// Brief    : Randomized self-checking bench for dcache_store_port against a line-level cache model.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_dcache_store_port;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_store = 1'b0, req_load = 1'b0, req_type = 1'b0;
    logic [31:0]  req_addr = '0, req_wdata = '0;
    logic         hit_dc, busy, mem_req, mem_we;
    logic [31:0]  rdata, mem_addr;
    logic [127:0] mem_wline;
    logic         mem_ack = 1'b0;
    logic [127:0] mem_rline = '0;

    always #5 clk = ~clk;

    dcache_store_port #(.INDEX_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .req_store(req_store), .req_load(req_load), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_type(req_type),
        .hit_dc(hit_dc), .rdata(rdata), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wline(mem_wline),
        .mem_ack(mem_ack), .mem_rline(mem_rline)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: each line remembers its full line address (addr >> 4)
    bit           m_valid [16];
    bit           m_dirty [16];
    int unsigned  m_line  [16];
    logic [127:0] m_data  [16];
    logic [127:0] mem_m   [int unsigned];
    logic [31:0]  exp_rdata;
    bit           ph_we   [$];
    logic [31:0]  ph_addr [$];
    logic [127:0] ph_data [$];

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        exp_rdata = 32'd0;
    endtask

    task automatic model_access(input bit st, input logic [31:0] a, input logic [31:0] wd, input bit by);
        int unsigned line;
        int          idx;
        line = a / 16;
        idx  = int'(line % 16);
        ph_we.delete();
        ph_addr.delete();
        ph_data.delete();
        if (!(m_valid[idx] && m_line[idx] == line)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                ph_we.push_back(1'b1);
                ph_addr.push_back(m_line[idx] * 16);
                ph_data.push_back(m_data[idx]);
                mem_m[m_line[idx]] = m_data[idx];
            end
            if (!mem_m.exists(line)) mem_m[line] = rand_line();
            ph_we.push_back(1'b0);
            ph_addr.push_back(line * 16);
            ph_data.push_back(mem_m[line]);
            m_data[idx]  = mem_m[line];
            m_valid[idx] = 1;
            m_dirty[idx] = 0;
            m_line[idx]  = line;
        end
        if (st) begin
            if (by) m_data[idx][(a % 16) * 8 +: 8] = wd[7:0];
            else    m_data[idx][((a / 4) % 4) * 32 +: 32] = wd;
            m_dirty[idx] = 1;
        end else begin
            exp_rdata = m_data[idx][((a / 4) % 4) * 32 +: 32];
        end
    endtask

    // delay < 0 picks a random ack delay; poke pulses req_load while memory is stalled
    task automatic run_req(input bit st, input bit ld, input logic [31:0] a, input logic [31:0] wd,
                           input bit by, input int delay, input bit poke);
        int d;
        model_access(st, a, wd, by);
        @(negedge clk);
        req_store = st; req_load = ld; req_addr = a; req_wdata = wd; req_type = by;
        @(posedge clk); #1;
        req_store = 1'b0; req_load = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        @(negedge clk);
        check("lookup_busy", busy, 1);
        check("lookup_mem_req", mem_req, 0);
        check("lookup_hit_dc", hit_dc, 0);
        foreach (ph_we[i]) begin
            @(negedge clk);
            check("phase_mem_req", mem_req, 1);
            check("phase_mem_we", mem_we, ph_we[i]);
            check("phase_mem_addr", mem_addr, ph_addr[i]);
            if (ph_we[i]) check("phase_mem_wline", mem_wline, ph_data[i]);
            d = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
            for (int k = 0; k < d; k++) begin
                if (poke && k == 0) req_load = 1'b1;
                @(posedge clk); #1;
                req_load = 1'b0;
                @(negedge clk);
                check("stall_mem_req", mem_req, 1);
                check("stall_mem_addr", mem_addr, ph_addr[i]);
                check("stall_busy", busy, 1);
                check("stall_hit_dc", hit_dc, 0);
            end
            mem_ack = 1'b1;
            mem_rline = ph_we[i] ? rand_line() : ph_data[i];
            @(posedge clk); #1;
            mem_ack = 1'b0;
            mem_rline = rand_line();
        end
        @(negedge clk);
        check("done_hit_dc", hit_dc, 0);
        check("done_mem_req", mem_req, 0);
        @(negedge clk);
        check("hit_dc", hit_dc, 1);
        check("idle_busy", busy, 0);
        check("rdata", rdata, exp_rdata);
        @(negedge clk);
        check("hit_dc_single", hit_dc, 0);
    endtask

    task automatic reset_mid_fill(input logic [31:0] a);
        @(negedge clk);
        req_load = 1'b1; req_addr = a; req_type = 1'b0;
        @(posedge clk); #1;
        req_load = 1'b0;
        repeat (3) @(negedge clk);
        check("fill_wait_mem_req", mem_req, 1);
        check("fill_wait_addr", mem_addr, a);
        #2 reset = 1'b1;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_hit_dc", hit_dc, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        bit          st, ld;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_hit_dc", hit_dc, 0);
        check("reset_rdata", rdata, 0);
        check("reset_busy", busy, 0);
        check("reset_mem_req", mem_req, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wline", mem_wline, 0);
        reset = 1'b0;

        mem_m[32'h4] = '0;
        run_req(1, 0, 32'h40, 32'hDEADBEEF, 0, -1, 0);
        run_req(0, 1, 32'h40, 32'h0, 0, -1, 0);
        check("load_40", rdata, 32'hDEADBEEF);
        run_req(1, 0, 32'h41, 32'h000000AA, 1, -1, 0);
        run_req(0, 1, 32'h40, 32'h0, 0, -1, 0);
        check("load_40_byte", rdata, 32'hDEADAAEF);
        run_req(1, 0, 32'h140, 32'h12345678, 0, -1, 0);
        run_req(0, 1, 32'h280, 32'h0, 0, 5, 1);
        reset_mid_fill(32'h380);
        run_req(0, 1, 32'h140, 32'h0, 0, -1, 0);
        run_req(1, 1, 32'h44, 32'h55667788, 0, -1, 0);

        for (int n = 0; n < 200; n++) begin
            a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            st = bit'($urandom_range(0, 1));
            ld = !st || ($urandom_range(0, 7) == 0);
            run_req(st, ld, a, $urandom, bit'($urandom_range(0, 1)), -1, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
